// File: rtl/vga_gradient_gen.sv
// vga_gradient_gen: multi-stop colour-gradient pixel generator between vga_sync and
// the RGB DAC pins. NUM_STOPS colour stops are interpolated along a horizontal,
// vertical or diagonal sweep through a 3-stage pipeline. Sync and video_on are
// delayed to stay aligned with the pixel.
// Ports: clk, reset (sync, active-high); x, y, video_on, hsync_in, vsync_in from
// vga_sync; frame_start (frame boundary pulse); sw/wr_stb/wr_idx stop write;
// mode_stb sweep-mode step; hsync, vsync, rgb, mode outputs.
// Build option: define FRAME_SYNC_EN to hold stop/mode updates in shadow registers
// until frame_start.
module vga_gradient_gen #(
  parameter int unsigned COLOR_W   = 12,
  parameter int unsigned NUM_STOPS = 2,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned COORD_W   = 10,
  localparam int unsigned IDX_W    = (NUM_STOPS > 2) ? $clog2(NUM_STOPS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               video_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               frame_start,
  input  logic [COLOR_W-1:0] sw,
  input  logic               wr_stb,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic               mode_stb,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb,
  output logic [1:0]         mode
);

  localparam int unsigned CH_W  = COLOR_W / 3;
  localparam int unsigned E_MAX = H_ACTIVE + V_ACTIVE;
  localparam int unsigned T_W   = (COORD_W + 1 > $clog2(E_MAX + 1)) ? COORD_W + 1 : $clog2(E_MAX + 1);
  localparam int unsigned P_W   = CH_W + T_W + 1;
  localparam int unsigned SEGS  = NUM_STOPS - 1;

  localparam logic [T_W-1:0]   E_H    = T_W'(H_ACTIVE);
  localparam logic [T_W-1:0]   E_V    = T_W'(V_ACTIVE);
  localparam logic [T_W-1:0]   E_D    = T_W'(E_MAX);
  localparam logic [T_W-1:0]   S_H    = T_W'(H_ACTIVE / SEGS);
  localparam logic [T_W-1:0]   S_V    = T_W'(V_ACTIVE / SEGS);
  localparam logic [T_W-1:0]   S_D    = T_W'(E_MAX / SEGS);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_STOPS - 2);

  typedef enum logic [1:0] {
    HORIZ = 2'd0,
    VERT  = 2'd1,
    DIAG  = 2'd2
  } mode_e;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      HORIZ:   return VERT;
      VERT:    return DIAG;
      default: return HORIZ;
    endcase
  endfunction

  logic [COLOR_W-1:0] stop_q [NUM_STOPS];
  logic [COLOR_W-1:0] stop_d [NUM_STOPS];
  mode_e              mode_q, mode_d;
  logic               wr_ok;

  assign wr_ok = wr_stb && (32'(wr_idx) < NUM_STOPS);

`ifdef FRAME_SYNC_EN
  logic [COLOR_W-1:0] stop_sh_q [NUM_STOPS];
  logic [COLOR_W-1:0] stop_sh_d [NUM_STOPS];
  mode_e              mode_sh_q, mode_sh_d;

  // Active set takes the shadow as it stood before this cycle's strobes.
  always_comb begin
    stop_sh_d = stop_sh_q;
    mode_sh_d = mode_sh_q;
    if (wr_ok)    stop_sh_d[wr_idx] = sw;
    if (mode_stb) mode_sh_d = mode_next(mode_sh_q);
    stop_d = stop_q;
    mode_d = mode_q;
    if (frame_start) begin
      stop_d = stop_sh_q;
      mode_d = mode_sh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STOPS; i++) stop_sh_q[i] <= '0;
      mode_sh_q <= HORIZ;
    end else begin
      stop_sh_q <= stop_sh_d;
      mode_sh_q <= mode_sh_d;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_comb begin
    stop_d = stop_q;
    mode_d = mode_q;
    if (wr_ok)    stop_d[wr_idx] = sw;
    if (mode_stb) mode_d = mode_next(mode_q);
  end
`endif

  // Stage 1: position, segment index, offset and segment length; colours sampled here.
  logic [T_W-1:0]     ext, pos, seg, t_cl, thr, base;
  logic [IDX_W-1:0]   k;
  logic [T_W-1:0]     u1_d, l1_d, u1_q, l1_q;
  logic [COLOR_W-1:0] clo_d, chi_d, clo_q, chi_q;
  logic [2:0]         dly1_q, dly2_q, dly3_q;  // {video_on, hsync, vsync}

  always_comb begin
    ext = E_H;
    pos = T_W'(x);
    seg = S_H;
    case (mode_q)
      VERT: begin
        ext = E_V;
        pos = T_W'(y);
        seg = S_V;
      end
      DIAG: begin
        ext = E_D;
        pos = T_W'(x) + T_W'(y);
        seg = S_D;
      end
      default: ;
    endcase
    t_cl = (pos >= ext) ? ext - T_W'(1) : pos;
    // k = min(t/S, NUM_STOPS-2) by threshold compare against constant multiples of S.
    k    = '0;
    base = '0;
    thr  = '0;
    for (int unsigned j = 1; j + 1 < NUM_STOPS; j++) begin
      thr = seg * T_W'(j);
      if (t_cl >= thr) begin
        k    = IDX_W'(j);
        base = thr;
      end
    end
    u1_d  = t_cl - base;
    l1_d  = (k == K_LAST) ? ext - seg * T_W'(NUM_STOPS - 2) : seg;
    clo_d = stop_q[k];
    chi_d = stop_q[k + IDX_W'(1)];
  end

  // Stage 2: per-channel weighted sums.
  logic [2:0][P_W-1:0] sum_d, sum_q;
  logic [T_W-1:0]      l2_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      sum_d[c] = P_W'(clo_q[c*CH_W +: CH_W]) * P_W'(l1_q - u1_q)
               + P_W'(chi_q[c*CH_W +: CH_W]) * P_W'(u1_q);
    end
  end

  // Stage 3: divide and blank. L is never 0 for valid pixels; guard keeps the reset state defined.
  logic [P_W-1:0]     denom, quo;
  logic [COLOR_W-1:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = '0;
    quo   = '0;
    denom = (l2_q == '0) ? P_W'(1) : P_W'(l2_q);
    for (int unsigned c = 0; c < 3; c++) begin
      quo = sum_q[c] / denom;
      rgb_d[c*CH_W +: CH_W] = dly2_q[2] ? CH_W'(quo) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STOPS; i++) stop_q[i] <= '0;
      mode_q <= HORIZ;
      u1_q   <= '0;
      l1_q   <= '0;
      clo_q  <= '0;
      chi_q  <= '0;
      sum_q  <= '0;
      l2_q   <= '0;
      rgb_q  <= '0;
      dly1_q <= '0;
      dly2_q <= '0;
      dly3_q <= '0;
    end else begin
      stop_q <= stop_d;
      mode_q <= mode_d;
      u1_q   <= u1_d;
      l1_q   <= l1_d;
      clo_q  <= clo_d;
      chi_q  <= chi_d;
      sum_q  <= sum_d;
      l2_q   <= l1_q;
      rgb_q  <= rgb_d;
      dly1_q <= {video_on, hsync_in, vsync_in};
      dly2_q <= dly1_q;
      dly3_q <= dly2_q;
    end
  end

  assign rgb   = rgb_q;
  assign hsync = dly3_q[1];
  assign vsync = dly3_q[0];
  assign mode  = mode_q;

endmodule

// File: tb/tb_vga_gradient_gen.sv
// Bench for vga_gradient_gen: a 2-stop and a 3-stop instance driven with directed
// steps followed by random pixels/strobes, checked against an arithmetic model.
module tb_vga_gradient_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] x, y;
  logic       video_on, hsync_in, vsync_in, frame_start;
  logic [11:0] sw;

  logic       wr_stb2, mode_stb2;
  logic [0:0] wr_idx2;
  logic       hsync2, vsync2;
  logic [11:0] rgb2;
  logic [1:0] mode2;

  logic       wr_stb3, mode_stb3;
  logic [1:0] wr_idx3;
  logic       hsync3, vsync3;
  logic [11:0] rgb3;
  logic [1:0] mode3;

  vga_gradient_gen #(.COLOR_W(12), .NUM_STOPS(2), .H_ACTIVE(640), .V_ACTIVE(480), .COORD_W(10)) u_dut2 (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .sw(sw), .wr_stb(wr_stb2), .wr_idx(wr_idx2), .mode_stb(mode_stb2),
    .hsync(hsync2), .vsync(vsync2), .rgb(rgb2), .mode(mode2)
  );

  vga_gradient_gen #(.COLOR_W(12), .NUM_STOPS(3), .H_ACTIVE(640), .V_ACTIVE(480), .COORD_W(10)) u_dut3 (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .sw(sw), .wr_stb(wr_stb3), .wr_idx(wr_idx3), .mode_stb(mode_stb3),
    .hsync(hsync3), .vsync(vsync3), .rgb(rgb3), .mode(mode3)
  );

  int tests = 0;
  int fails = 0;

  logic [11:0] m_stop [2][8];
  int          m_mode [2];
`ifdef FRAME_SYNC_EN
  logic [11:0] sh_stop [2][8];
  int          sh_mode [2];
`endif

  typedef struct {
    logic [11:0] rgb2;
    logic [11:0] rgb3;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nstops(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // Gradient value straight from the interpolation rules.
  function automatic logic [11:0] ref_pix(input int d, input int xi, input int yi);
    int n, e, t, s, k, u, l, a, b;
    logic [11:0] lo, hi, r;
    n = nstops(d);
    case (m_mode[d])
      0:       begin e = 640;  t = xi;      end
      1:       begin e = 480;  t = yi;      end
      default: begin e = 1120; t = xi + yi; end
    endcase
    if (t >= e) t = e - 1;
    s = e / (n - 1);
    k = t / s;
    if (k > n - 2) k = n - 2;
    u = t - k * s;
    l = (k < n - 2) ? s : e - (n - 2) * s;
    lo = m_stop[d][k];
    hi = m_stop[d][k + 1];
    r = '0;
    for (int c = 0; c < 3; c++) begin
      a = int'(lo[4*c +: 4]);
      b = int'(hi[4*c +: 4]);
      r[4*c +: 4] = 4'((a * (l - u) + b * u) / l);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_stop[d][i] = '0;
      m_mode[d] = 0;
`ifdef FRAME_SYNC_EN
      for (int i = 0; i < 8; i++) sh_stop[d][i] = '0;
      sh_mode[d] = 0;
`endif
    end
    q.delete();
  endtask

  task automatic model_update();
    logic ws [2];
    int   wi [2];
    logic ms [2];
    ws[0] = wr_stb2; wi[0] = int'(wr_idx2); ms[0] = mode_stb2;
    ws[1] = wr_stb3; wi[1] = int'(wr_idx3); ms[1] = mode_stb3;
    for (int d = 0; d < 2; d++) begin
`ifdef FRAME_SYNC_EN
      if (frame_start) begin
        for (int i = 0; i < 8; i++) m_stop[d][i] = sh_stop[d][i];
        m_mode[d] = sh_mode[d];
      end
      if (ws[d] && wi[d] < nstops(d)) sh_stop[d][wi[d]] = sw;
      if (ms[d]) sh_mode[d] = (sh_mode[d] + 1) % 3;
`else
      if (ws[d] && wi[d] < nstops(d)) m_stop[d][wi[d]] = sw;
      if (ms[d]) m_mode[d] = (m_mode[d] + 1) % 3;
`endif
    end
  endtask

  // One clock: queue the expectation for the inputs now applied, clock, then check.
  task automatic cycle();
    exp_t e, o;
    e.rgb2 = video_on ? ref_pix(0, int'(x), int'(y)) : 12'h000;
    e.rgb3 = video_on ? ref_pix(1, int'(x), int'(y)) : 12'h000;
    e.hs   = hsync_in;
    e.vs   = vsync_in;
    q.push_back(e);
    @(posedge clk);
    model_update();
    #1;
    check("mode2", 32'(mode2), 32'(m_mode[0]));
    check("mode3", 32'(mode3), 32'(m_mode[1]));
    if (q.size() >= 3) begin
      o = q.pop_front();
      check("rgb2",   32'(rgb2),   32'(o.rgb2));
      check("rgb3",   32'(rgb3),   32'(o.rgb3));
      check("hsync2", 32'(hsync2), 32'(o.hs));
      check("vsync2", 32'(vsync2), 32'(o.vs));
      check("hsync3", 32'(hsync3), 32'(o.hs));
      check("vsync3", 32'(vsync3), 32'(o.vs));
    end
    wr_stb2 = 1'b0; mode_stb2 = 1'b0;
    wr_stb3 = 1'b0; mode_stb3 = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_stb2 = 1'b0; mode_stb2 = 1'b0; wr_stb3 = 1'b0; mode_stb3 = 1'b0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rgb2",  32'(rgb2),   32'h0);
    check("rst_rgb3",  32'(rgb3),   32'h0);
    check("rst_hs2",   32'(hsync2), 32'h0);
    check("rst_vs2",   32'(vsync2), 32'h0);
    check("rst_hs3",   32'(hsync3), 32'h0);
    check("rst_mode2", 32'(mode2),  32'h0);
    check("rst_mode3", 32'(mode3),  32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr2(input logic idx, input logic [11:0] v);
    wr_stb2 = 1'b1; wr_idx2 = idx; sw = v;
    cycle();
  endtask

  task automatic wr3(input logic [1:0] idx, input logic [11:0] v);
    wr_stb3 = 1'b1; wr_idx3 = idx; sw = v;
    cycle();
  endtask

  task automatic commit();
    frame_start = 1'b1;
    cycle();
  endtask

  task automatic pix(input int xi, input int yi);
    x = 10'(xi); y = 10'(yi); video_on = 1'b1;
    cycle();
  endtask

  task automatic drain();
    video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      x        = 10'($urandom_range(0, 799));
      y        = 10'($urandom_range(0, 524));
      video_on = ($urandom_range(0, 3) != 0);
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      sw       = 12'($urandom);
      wr_stb2  = ($urandom_range(0, 7) == 0);
      wr_idx2  = 1'($urandom_range(0, 1));
      wr_stb3  = ($urandom_range(0, 7) == 0);
      wr_idx3  = 2'($urandom_range(0, 3));
      mode_stb2 = ($urandom_range(0, 9) == 0);
      mode_stb3 = ($urandom_range(0, 9) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    x = '0; y = '0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    frame_start = 1'b0; sw = '0;
    wr_stb2 = 1'b0; wr_idx2 = '0; mode_stb2 = 1'b0;
    wr_stb3 = 1'b0; wr_idx3 = '0; mode_stb3 = 1'b0;

    do_reset();

    // Stops: 2-stop F00->00F, 3-stop F00->0F0->00F.
    wr2(1'b0, 12'hF00);
    wr2(1'b1, 12'h00F);
    wr3(2'd0, 12'hF00);
    wr3(2'd1, 12'h0F0);
    wr3(2'd2, 12'h00F);
    commit();

    // Horizontal sweep incl. right edge and blanking clamp.
    pix(0, 0);
    pix(320, 0);
    pix(639, 0);
    pix(720, 0);

    // Vertical sweep on the 2-stop instance.
    mode_stb2 = 1'b1;
    cycle();
    commit();
    pix(0, 0);
    pix(0, 240);
    pix(0, 479);
    pix(0, 510);

    // Diagonal sweep on the 3-stop instance.
    mode_stb3 = 1'b1;
    cycle();
    mode_stb3 = 1'b1;
    cycle();
    commit();
    pix(0, 0);
    pix(280, 280);
    pix(560, 0);
    pix(639, 479);

    // Blanked pixel and a 2-cycle hsync pulse followed by a vsync pulse.
    x = 10'd100; y = 10'd0; video_on = 1'b0;
    cycle();
    hsync_in = 1'b1; cycle(); cycle();
    hsync_in = 1'b0; vsync_in = 1'b1; cycle();
    vsync_in = 1'b0; cycle();
    drain();

    // Simultaneous write and mode step; out-of-range write index.
    wr_stb2 = 1'b1; wr_idx2 = 1'b1; sw = 12'h0F0; mode_stb2 = 1'b1;
    wr_stb3 = 1'b1; wr_idx3 = 2'd3; sw = 12'h0F0;
    cycle();
    commit();
    pix(100, 100);
    pix(300, 400);
    pix(639, 479);
    drain();

`ifdef FRAME_SYNC_EN
    // Deferred update: stop0 write mid-frame stays hidden until frame_start.
    mode_stb2 = 1'b1;
    cycle();
    commit();
    wr2(1'b0, 12'hFFF);
    pix(0, 0);
    pix(0, 0);
    frame_start = 1'b1;
    pix(0, 0);
    pix(0, 0);
    pix(0, 0);
    drain();
`endif

    random_run(600);

    // Reset in the middle of a busy stream.
    x = 10'd50; y = 10'd60; video_on = 1'b1;
    do_reset();
    random_run(150);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
